// File: rtl/proc_pkg.sv
// Shared pipeline types and widths for the decode/execute boundary.
// Opcode constants here are the same encoding the decoder emits.
package proc_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;
    localparam int OP_W   = 5;

    localparam logic [OP_W-1:0] OP_ADD = 5'd0;
    localparam logic [OP_W-1:0] OP_SUB = 5'd1;
    localparam logic [OP_W-1:0] OP_LD  = 5'd2;
    localparam logic [OP_W-1:0] OP_ST  = 5'd3;
    localparam logic [OP_W-1:0] OP_BEQ = 5'd4;

    typedef enum logic {
        RUN    = 1'b0,
        BUBBLE = 1'b1
    } state_t;

endpackage

// File: rtl/id_ex_if.sv
// ID/EX boundary bundle: decoded instruction in, EX-stage registers and stall out.
// master = decode/pipeline control side, slave = the id_ex_stage register.
interface id_ex_if
    import proc_pkg::*;
#(
    parameter int DATA_W = proc_pkg::DATA_W,
    parameter int ADDR_W = proc_pkg::ADDR_W,
    parameter int OP_W   = proc_pkg::OP_W
);
    logic              in_valid;
    logic [OP_W-1:0]   opcode;
    logic [ADDR_W-1:0] dst_addr;
    logic [ADDR_W-1:0] src_addr;
    logic [DATA_W-1:0] read_data1;
    logic [DATA_W-1:0] read_data2;
    logic [DATA_W-1:0] imm;
    logic              ctrl_mem_read;
    logic              ctrl_reg_write;
    logic              ex_stall;
    logic              flush;

    logic              ex_valid;
    logic              ex_mem_read;
    logic              ex_reg_write;
    logic [OP_W-1:0]   ex_opcode;
    logic [ADDR_W-1:0] ex_dst_addr;
    logic [ADDR_W-1:0] ex_src_addr;
    logic [DATA_W-1:0] ex_op1;
    logic [DATA_W-1:0] ex_op2;
    logic [DATA_W-1:0] ex_imm;
    logic              id_stall;

    modport master (
        output in_valid, opcode, dst_addr, src_addr, read_data1, read_data2, imm,
               ctrl_mem_read, ctrl_reg_write, ex_stall, flush,
        input  ex_valid, ex_mem_read, ex_reg_write, ex_opcode, ex_dst_addr,
               ex_src_addr, ex_op1, ex_op2, ex_imm, id_stall
    );

    modport slave (
        input  in_valid, opcode, dst_addr, src_addr, read_data1, read_data2, imm,
               ctrl_mem_read, ctrl_reg_write, ex_stall, flush,
        output ex_valid, ex_mem_read, ex_reg_write, ex_opcode, ex_dst_addr,
               ex_src_addr, ex_op1, ex_op2, ex_imm, id_stall
    );

endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use comparator: the instruction in EX is a load whose result the ID
// instruction names as either register operand.
module hazard_detect #(
    parameter int ADDR_W = proc_pkg::ADDR_W
) (
    input  logic              enable,
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic              ex_reg_write,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] ex_dst_addr,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    output logic              hazard
);

    assign hazard = enable && ex_valid && ex_mem_read && ex_reg_write && in_valid &&
                    ((ex_dst_addr == src_addr) || (ex_dst_addr == dst_addr));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with flush, downstream hold and optional load-use
// bubble insertion (enabled by defining ID_EX_HAZARD_DETECT_EN).
module id_ex_stage
    import proc_pkg::*;
#(
    parameter int DATA_W = proc_pkg::DATA_W,
    parameter int ADDR_W = proc_pkg::ADDR_W,
    parameter int OP_W   = proc_pkg::OP_W
) (
    input  logic    clk,
    input  logic    reset,
    id_ex_if.slave  bus
);

    logic hazard;
    logic clear_en;
    logic load_en;

`ifdef ID_EX_HAZARD_DETECT_EN
    state_t state;
    state_t state_nx;

    // The cycle after a bubble the held instruction must go through, so the
    // comparator is muted while in BUBBLE.
    hazard_detect #(.ADDR_W(ADDR_W)) u_hazard_detect (
        .enable      (state == RUN),
        .ex_valid    (bus.ex_valid),
        .ex_mem_read (bus.ex_mem_read),
        .ex_reg_write(bus.ex_reg_write),
        .in_valid    (bus.in_valid),
        .ex_dst_addr (bus.ex_dst_addr),
        .src_addr    (bus.src_addr),
        .dst_addr    (bus.dst_addr),
        .hazard      (hazard)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (bus.flush) begin
            state_nx = RUN;
        end else if (bus.ex_stall) begin
            state_nx = state;
        end else if (state == BUBBLE) begin
            state_nx = RUN;
        end else if (hazard) begin
            state_nx = BUBBLE;
        end
    end
`else
    assign hazard = 1'b0;
`endif

    assign clear_en = reset || bus.flush || (!bus.ex_stall && (hazard || !bus.in_valid));
    assign load_en  = !bus.ex_stall;

    always_ff @(posedge clk) begin
        if (clear_en) begin
            bus.ex_valid     <= 1'b0;
            bus.ex_mem_read  <= 1'b0;
            bus.ex_reg_write <= 1'b0;
            bus.ex_opcode    <= '0;
            bus.ex_dst_addr  <= '0;
            bus.ex_src_addr  <= '0;
            bus.ex_op1       <= '0;
            bus.ex_op2       <= '0;
            bus.ex_imm       <= '0;
        end else if (load_en) begin
            bus.ex_valid     <= bus.in_valid;
            bus.ex_mem_read  <= bus.ctrl_mem_read;
            bus.ex_reg_write <= bus.ctrl_reg_write;
            bus.ex_opcode    <= bus.opcode;
            bus.ex_dst_addr  <= bus.dst_addr;
            bus.ex_src_addr  <= bus.src_addr;
            bus.ex_op1       <= bus.read_data1;
            bus.ex_op2       <= bus.read_data2;
            bus.ex_imm       <= bus.imm;
        end
    end

    // Reset gates the stall so nothing upstream freezes while the pipe clears.
    assign bus.id_stall = !reset && !bus.flush && (bus.ex_stall || hazard);

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a vector table plus hand-written multi-cycle
// sequences; hazard expectations follow ID_EX_HAZARD_DETECT_EN.
module tb_id_ex_stage;
    import proc_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    id_ex_if bus ();

    id_ex_stage dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        in_valid;
        logic [4:0]  opcode;
        logic [2:0]  dst;
        logic [2:0]  src;
        logic [15:0] rd1;
        logic [15:0] rd2;
        logic [15:0] imm;
        logic        mr;
        logic        rw;
        logic        stall;
        logic        flush;
    } stim_t;

    typedef struct {
        logic        valid;
        logic        mr;
        logic        rw;
        logic [4:0]  opcode;
        logic [2:0]  dst;
        logic [2:0]  src;
        logic [15:0] op1;
        logic [15:0] op2;
        logic [15:0] imm;
    } exp_t;

    typedef struct {
        stim_t s;
        logic  id_stall;
        exp_t  e;
    } vec_t;

    function automatic stim_t mk(logic v, logic [4:0] op, logic [2:0] d, logic [2:0] sr,
                                 logic [15:0] r1, logic [15:0] r2, logic [15:0] im,
                                 logic mr, logic rw, logic st, logic fl);
        stim_t s;
        s.in_valid = v;  s.opcode = op; s.dst = d;  s.src = sr;
        s.rd1 = r1;      s.rd2 = r2;    s.imm = im;
        s.mr = mr;       s.rw = rw;     s.stall = st; s.flush = fl;
        return s;
    endfunction

    function automatic exp_t mke(logic v, logic mr, logic rw, logic [4:0] op, logic [2:0] d,
                                 logic [2:0] sr, logic [15:0] o1, logic [15:0] o2,
                                 logic [15:0] im);
        exp_t e;
        e.valid = v; e.mr = mr; e.rw = rw; e.opcode = op; e.dst = d; e.src = sr;
        e.op1 = o1;  e.op2 = o2; e.imm = im;
        return e;
    endfunction

    task automatic check(string name, logic [15:0] act, logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(stim_t s);
        bus.in_valid       = s.in_valid;
        bus.opcode         = s.opcode;
        bus.dst_addr       = s.dst;
        bus.src_addr       = s.src;
        bus.read_data1     = s.rd1;
        bus.read_data2     = s.rd2;
        bus.imm            = s.imm;
        bus.ctrl_mem_read  = s.mr;
        bus.ctrl_reg_write = s.rw;
        bus.ex_stall       = s.stall;
        bus.flush          = s.flush;
    endtask

    task automatic check_ex(string tag, exp_t e);
        check({tag, " ex_valid"},     16'(bus.ex_valid),     16'(e.valid));
        check({tag, " ex_mem_read"},  16'(bus.ex_mem_read),  16'(e.mr));
        check({tag, " ex_reg_write"}, 16'(bus.ex_reg_write), 16'(e.rw));
        check({tag, " ex_opcode"},    16'(bus.ex_opcode),    16'(e.opcode));
        check({tag, " ex_dst_addr"},  16'(bus.ex_dst_addr),  16'(e.dst));
        check({tag, " ex_src_addr"},  16'(bus.ex_src_addr),  16'(e.src));
        check({tag, " ex_op1"},       bus.ex_op1,            e.op1);
        check({tag, " ex_op2"},       bus.ex_op2,            e.op2);
        check({tag, " ex_imm"},       bus.ex_imm,            e.imm);
    endtask

    // Drive on the falling edge, check id_stall before the rising edge and the
    // EX registers just after it.
    task automatic step(string tag, stim_t s, logic exp_stall, exp_t e);
        @(negedge clk);
        apply(s);
        #1;
        check({tag, " id_stall"}, 16'(bus.id_stall), 16'(exp_stall));
        @(posedge clk);
        #1;
        check_ex(tag, e);
    endtask

    vec_t  tbl [8];
    exp_t  bub;
    stim_t idle, ld2, use_r2, use_dst2, fl, beef, st;
    exp_t  e_ld2, e_use, e_use_dst2, e_beef, e_st;

    initial begin
        bub  = mke(0, 0, 0, 5'd0, 3'd0, 3'd0, 16'h0000, 16'h0000, 16'h0000);
        idle = mk(0, 5'd0, 3'd0, 3'd0, 16'h0, 16'h0, 16'h0, 0, 0, 0, 0);

        tbl[0] = '{mk(1, OP_ADD, 3, 1, 16'h1234, 16'h00FF, 16'h0005, 0, 1, 0, 0), 1'b0,
                   mke(1, 0, 1, OP_ADD, 3, 1, 16'h1234, 16'h00FF, 16'h0005)};
        tbl[1] = '{mk(1, OP_LD, 6, 7, 16'hAAAA, 16'hBBBB, 16'hCCCC, 1, 1, 1, 0), 1'b1,
                   mke(1, 0, 1, OP_ADD, 3, 1, 16'h1234, 16'h00FF, 16'h0005)};
        tbl[2] = '{mk(0, OP_SUB, 4, 5, 16'h5A5A, 16'hA5A5, 16'h0F00, 1, 1, 0, 0), 1'b0, bub};
        tbl[3] = '{mk(1, OP_LD, 2, 0, 16'h1111, 16'h2222, 16'h0010, 1, 1, 0, 0), 1'b0,
                   mke(1, 1, 1, OP_LD, 2, 0, 16'h1111, 16'h2222, 16'h0010)};
        tbl[4] = '{mk(1, OP_ADD, 4, 5, 16'h4444, 16'h5555, 16'h0001, 0, 1, 0, 0), 1'b0,
                   mke(1, 0, 1, OP_ADD, 4, 5, 16'h4444, 16'h5555, 16'h0001)};
        tbl[5] = '{mk(1, OP_ST, 1, 1, 16'h9999, 16'h8888, 16'h7777, 0, 1, 1, 1), 1'b0, bub};
        tbl[6] = '{mk(1, OP_LD, 2, 3, 16'h0F0F, 16'hF0F0, 16'h0002, 1, 0, 0, 0), 1'b0,
                   mke(1, 1, 0, OP_LD, 2, 3, 16'h0F0F, 16'hF0F0, 16'h0002)};
        tbl[7] = '{mk(1, OP_SUB, 5, 2, 16'hABCD, 16'hDCBA, 16'h0000, 0, 1, 0, 0), 1'b0,
                   mke(1, 0, 1, OP_SUB, 5, 2, 16'hABCD, 16'hDCBA, 16'h0000)};

        ld2        = mk(1, OP_LD, 2, 0, 16'h0A0A, 16'h0B0B, 16'h0004, 1, 1, 0, 0);
        e_ld2      = mke(1, 1, 1, OP_LD, 2, 0, 16'h0A0A, 16'h0B0B, 16'h0004);
        use_r2     = mk(1, OP_ADD, 6, 2, 16'h1357, 16'h2468, 16'h0003, 0, 1, 0, 0);
        e_use      = mke(1, 0, 1, OP_ADD, 6, 2, 16'h1357, 16'h2468, 16'h0003);
        use_dst2   = mk(1, OP_ST, 2, 0, 16'h3333, 16'h6666, 16'h0008, 0, 0, 0, 0);
        e_use_dst2 = mke(1, 0, 0, OP_ST, 2, 0, 16'h3333, 16'h6666, 16'h0008);
        beef       = mk(1, OP_ADD, 7, 1, 16'hBEEF, 16'h0042, 16'h0009, 0, 1, 0, 0);
        e_beef     = mke(1, 0, 1, OP_ADD, 7, 1, 16'hBEEF, 16'h0042, 16'h0009);
        st         = mk(1, OP_SUB, 1, 7, 16'h7E57, 16'h0001, 16'h0006, 0, 1, 1, 0);
        e_st       = mke(1, 0, 1, OP_SUB, 1, 7, 16'h7E57, 16'h0001, 16'h0006);

        // Reset with a stall request pending: stall must stay low.
        apply(idle);
        bus.ex_stall = 1'b1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset id_stall", 16'(bus.id_stall), 16'h0);
        check_ex("reset", bub);
        @(negedge clk);
        bus.ex_stall = 1'b0;
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            step($sformatf("vec%0d", i), tbl[i].s, tbl[i].id_stall, tbl[i].e);
        end

        // Load-use on src_addr.
        step("lu_load", ld2, 1'b0, e_ld2);
`ifdef ID_EX_HAZARD_DETECT_EN
        step("lu_hazard", use_r2, 1'b1, bub);
        step("lu_reload", use_r2, 1'b0, e_use);
`else
        step("lu_nostall", use_r2, 1'b0, e_use);
`endif

        // Flush beats the hazard in the same cycle.
        step("fl_load", ld2, 1'b0, e_ld2);
        fl = use_r2;
        fl.flush = 1'b1;
        step("fl_hazard", fl, 1'b0, bub);
        step("fl_after", use_r2, 1'b0, e_use);

        // Three-cycle downstream hold.
        step("hold_load", beef, 1'b0, e_beef);
        for (int i = 0; i < 3; i++) begin
            step($sformatf("hold%0d", i), st, 1'b1, e_beef);
        end
        st.stall = 1'b0;
        step("hold_release", st, 1'b0, e_st);

`ifdef ID_EX_HAZARD_DETECT_EN
        // Downstream hold while a bubble sits in EX: the bubble is kept.
        step("bh_load", ld2, 1'b0, e_ld2);
        step("bh_hazard", use_r2, 1'b1, bub);
        use_r2.stall = 1'b1;
        step("bh_hold0", use_r2, 1'b1, bub);
        step("bh_hold1", use_r2, 1'b1, bub);
        use_r2.stall = 1'b0;
        step("bh_exit", use_r2, 1'b0, e_use);
`endif

        // Reset while in BUBBLE (hazard via dst_addr match) with ex_stall high.
        step("rb_load", ld2, 1'b0, e_ld2);
`ifdef ID_EX_HAZARD_DETECT_EN
        step("rb_hazard", use_dst2, 1'b1, bub);
`else
        step("rb_nohazard", use_dst2, 1'b0, e_use_dst2);
`endif
        @(negedge clk);
        reset = 1'b1;
        bus.ex_stall = 1'b1;
        #1;
        check("rb_reset id_stall", 16'(bus.id_stall), 16'h0);
        @(posedge clk);
        #1;
        check_ex("rb_reset", bub);
        @(negedge clk);
        #1;
        check("rb_reset2 id_stall", 16'(bus.id_stall), 16'h0);
        reset = 1'b0;
        step("rb_after", use_dst2, 1'b0, e_use_dst2);

        // Comparator live again after reset.
        step("rb_ld2", ld2, 1'b0, e_ld2);
`ifdef ID_EX_HAZARD_DETECT_EN
        step("rb_rerun", use_r2, 1'b1, bub);
`else
        step("rb_rerun", use_r2, 1'b0, e_use);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
